follow_stim_driver: RTL and testbench

//  Self-checking stimulus source for single-bit follow-type DUTs (out == in delayed by LATENCY clocks).

---
 rtl/follow_stim_driver.sv | 125 ++++++++++++
 tb/tb_follow_stim_driver.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/follow_stim_driver.sv
// Self-checking stimulus source for single-bit follow-type DUTs (out == in delayed by LATENCY).
// Drives an LFSR bit stream, checks the DUT output against a delayed copy, reports errors.
module follow_stim_driver #(
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned NUM_VECTORS = 16,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5,
  parameter int unsigned ERR_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             dut_in,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [15:0]      first_err_idx
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [7:0]  SEED       = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [15:0] LAST_VEC   = 16'(NUM_VECTORS - 1);
  localparam logic [15:0] LAST_DRAIN = 16'(LATENCY - 1);

  logic [1:0]         state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic [LATENCY-1:0] dly_q, dly_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [15:0]        cmp_idx_q, cmp_idx_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [15:0]        first_q, first_d;
  logic               stim;
  logic               fb;

  assign stim = (state_q == S_DRIVE) && lfsr_q[0];
  assign fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    cmp_idx_d = cmp_idx_q;
    err_d     = err_q;
    first_d   = first_q;
    dly_d     = (dly_q << 1) | LATENCY'(stim);
    vld_d     = (vld_q << 1) | LATENCY'(state_q == S_DRIVE);

    // Case inequality so an X/Z output in simulation is scored as a mismatch.
    if (vld_q[LATENCY-1]) begin
      cmp_idx_d = cmp_idx_q + 16'd1;
      if (dut_out !== dly_q[LATENCY-1]) begin
        if (err_q != '1) err_d = err_q + ERR_W'(1);
        if (err_q == '0) first_d = cmp_idx_q;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_DRIVE;
          cnt_d     = '0;
          lfsr_d    = SEED;
          cmp_idx_d = '0;
          err_d     = '0;
          first_d   = '0;
          dly_d     = '0;
          vld_d     = '0;
        end
      end
      S_DRIVE: begin
        lfsr_d = {lfsr_q[6:0], fb};
        if (cnt_q == LAST_VEC) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        if (cnt_q == LAST_DRAIN) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      lfsr_q    <= SEED;
      dly_q     <= '0;
      vld_q     <= '0;
      cmp_idx_q <= '0;
      err_q     <= '0;
      first_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      dly_q     <= dly_d;
      vld_q     <= vld_d;
      cmp_idx_q <= cmp_idx_d;
      err_q     <= err_d;
      first_q   <= first_d;
    end
  end

  assign dut_in        = stim;
  assign busy          = (state_q == S_DRIVE) || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign pass          = done && (err_q == '0);
  assign err_count     = err_q;
  assign first_err_idx = first_q;

endmodule

// File: tb/tb_follow_stim_driver.sv
// Bench for follow_stim_driver: three instances (default, ERR_W=3, LATENCY=3) against small DUT models.
module tb_follow_stim_driver;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic        dut_in_a, dut_out_a, busy_a, done_a, pass_a;
  logic [7:0]  err_a;
  logic [15:0] first_a;
  logic        dut_in_b, dut_out_b, busy_b, done_b, pass_b;
  logic [2:0]  err_b;
  logic [15:0] first_b;
  logic        dut_in_c, dut_out_c, busy_c, done_c, pass_c;
  logic [7:0]  err_c;
  logic [15:0] first_c;

  follow_stim_driver #(.LATENCY(1), .NUM_VECTORS(16), .LFSR_SEED(8'hA5), .ERR_W(8)) u_a (
    .clk(clk), .reset(reset), .start(start), .dut_in(dut_in_a), .dut_out(dut_out_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .first_err_idx(first_a));

  follow_stim_driver #(.LATENCY(1), .NUM_VECTORS(16), .LFSR_SEED(8'hA5), .ERR_W(3)) u_b (
    .clk(clk), .reset(reset), .start(start), .dut_in(dut_in_b), .dut_out(dut_out_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .first_err_idx(first_b));

  follow_stim_driver #(.LATENCY(3), .NUM_VECTORS(16), .LFSR_SEED(8'hA5), .ERR_W(8)) u_c (
    .clk(clk), .reset(reset), .start(start), .dut_in(dut_in_c), .dut_out(dut_out_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c), .first_err_idx(first_c));

  // Follow-DUT models; u_a's one can corrupt a single chosen vector.
  logic        inv = 1'b0;
  logic        bad_en = 1'b0;
  logic [15:0] bad_idx = '0;
  logic [15:0] k_q = '0;
  logic [15:0] idx_a = '0;
  logic        ff_a = 1'b0, ff_b = 1'b0;
  logic [2:0]  ff_c = '0;

  always @(posedge clk) begin
    k_q   <= busy_a ? k_q + 16'd1 : 16'd0;
    idx_a <= k_q;
    ff_a  <= dut_in_a;
    ff_b  <= dut_in_b;
    ff_c  <= {ff_c[1:0], dut_in_c};
  end

  assign dut_out_a = ff_a ^ (inv | (bad_en && idx_a == bad_idx));
  assign dut_out_b = ff_b ^ inv;
  assign dut_out_c = ff_c[2];

  int n_checks = 0;
  int n_errs = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic        inv;
    logic        bad_en;
    logic [15:0] bad_idx;
    int          exp_err_a;
    int          exp_first_a;
    int          exp_pass_a;
    int          exp_err_b;
    int          exp_pass_b;
  } vec_t;

  vec_t vecs[5];
  logic [4:0] cap;

  // Pulses start, waits (bounded) for u_c done; returns u_a busy length and cycles to u_c done.
  task automatic do_run(output int busy_len, output int to_done);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_len = 0;
    to_done = 0;
    cap = '0;
    for (int i = 0; i < 100; i++) begin
      to_done++;
      if (busy_a) busy_len++;
      if (busy_a && k_q < 16'd5) cap[k_q[2:0]] = dut_in_a;
      if (done_c) break;
      @(negedge clk);
    end
  endtask

  initial begin
    int bl, td;
    vecs[0] = '{1'b0, 1'b0, 16'd0,  0,  0, 1, 0, 1};
    vecs[1] = '{1'b1, 1'b0, 16'd0,  16, 0, 0, 7, 0};
    vecs[2] = '{1'b0, 1'b1, 16'd5,  1,  5, 0, 0, 1};
    vecs[3] = '{1'b0, 1'b1, 16'd15, 1, 15, 0, 0, 1};
    vecs[4] = '{1'b0, 1'b1, 16'd0,  1,  0, 0, 0, 1};

    repeat (3) @(negedge clk);
    check("reset_outputs", int'({dut_in_a, busy_a, done_a, pass_a, err_a, first_a}), 0);
    check("reset_c", int'({busy_c, done_c, pass_c, err_c}), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 5; r++) begin
      inv = vecs[r].inv;
      bad_en = vecs[r].bad_en;
      bad_idx = vecs[r].bad_idx;
      do_run(bl, td);
      check($sformatf("r%0d_done_c", r), int'(done_c), 1);
      check($sformatf("r%0d_busy_len", r), bl, 17);
      check($sformatf("r%0d_stream", r), int'(cap), 5'b00101);
      check($sformatf("r%0d_done_a", r), int'(done_a), 1);
      check($sformatf("r%0d_err_a", r), int'(err_a), vecs[r].exp_err_a);
      if (vecs[r].exp_err_a != 0)
        check($sformatf("r%0d_first_a", r), int'(first_a), vecs[r].exp_first_a);
      check($sformatf("r%0d_pass_a", r), int'(pass_a), vecs[r].exp_pass_a);
      check($sformatf("r%0d_err_b", r), int'(err_b), vecs[r].exp_err_b);
      check($sformatf("r%0d_pass_b", r), int'(pass_b), vecs[r].exp_pass_b);
      check($sformatf("r%0d_pass_c", r), int'(pass_c), 1);
      repeat (3) @(negedge clk);
      check($sformatf("r%0d_hold", r), int'({done_a, err_a}), int'({1'b1, 8'(vecs[r].exp_err_a)}));
    end

    // Reset during DRIVE cycle 4 aborts the run, then a clean run passes.
    inv = 1'b0;
    bad_en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy_before_reset", int'(busy_a), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_reset_outputs", int'({dut_in_a, busy_a, done_a, pass_a, err_a, first_a}), 0);
    check("mid_reset_c", int'({busy_c, done_c, pass_c}), 0);
    @(negedge clk);
    do_run(bl, td);
    check("after_reset_busy_len", bl, 17);
    check("after_reset_pass_a", int'(pass_a), 1);

    // start held high: LATENCY=3 run is not restarted, done lasts one cycle then restarts.
    start = 1'b1;
    td = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      td++;
      if (done_c) break;
    end
    check("hold_done_time", td, 20);
    check("hold_pass_c", int'(pass_c), 1);
    @(negedge clk);
    check("hold_restart", int'({done_c, busy_c}), 2'b01);
    start = 1'b0;
    td = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      td++;
      if (done_c) break;
    end
    check("hold_second_run_time", td, 19);
    check("hold_second_pass_c", int'(pass_c), 1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
